// File: rtl/mem_line_master_if.sv
// Cache-side request/response channel of the line master.
// The cache drives requests through "master"; the line master answers through "slave".
interface mem_line_master_if #(
  parameter int ADDR_W = 15,
  parameter int LINE_W = 128
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_line_master.sv
// Bus-2 line master: serialises 16-byte cache lines into 16-bit beats on C2/D2/A2
// and collects the memory response.
//
// state   | meaning
// IDLE    | ready for a request, drives C2=NOP
// RD_CMD  | one cycle of C2=READ_LINE
// RD_WAIT | bus released, waiting for the first RESPONSE beat
// RD_DATA | collecting beats 1..LINE_BEATS-1
// WR_DATA | driving C2=WRITE_LINE with one data beat per cycle
// WR_WAIT | bus released, waiting for the RESPONSE acknowledge
// DONE    | resp_valid pulse
// ERR     | resp_err pulse after a memory timeout
module mem_line_master #(
  parameter int LINE_BEATS = 8,
  parameter int ADDR_W     = 15,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              RESET,
  mem_line_master_if.slave  req_if,
  output logic [ADDR_W-1:0] A2,
  inout  wire  [1:0]        C2,
  inout  wire  [15:0]       D2
);
  localparam int LINE_W = LINE_BEATS * 16;
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RESP = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_WR   = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CMD, S_RD_WAIT, S_RD_DATA, S_WR_DATA, S_WR_WAIT, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  rbuf_q, rbuf_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               c2_oe, d2_oe;
  logic [1:0]         c2_out;
  logic [15:0]        d2_out;
  logic [TMO_W-1:0]   tmo_inc;
  logic [BEAT_W-1:0]  beat_inc;
  logic               resp_seen;

  assign resp_seen = (C2 == CMD_RESP);
  assign tmo_inc   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
  assign beat_inc  = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    c2_oe   = 1'b0;
    d2_oe   = 1'b0;
    c2_out  = CMD_NOP;
    d2_out  = '0;

    case (state_q)
      S_IDLE: begin
        c2_oe = 1'b1;
        if (req_if.req_valid) begin
          addr_d  = req_if.req_addr;
          wdata_d = req_if.req_wdata;
          beat_d  = '0;
          tmo_d   = '0;
          state_d = req_if.req_write ? S_WR_DATA : S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        c2_oe   = 1'b1;
        c2_out  = CMD_RD;
        tmo_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // The first RESPONSE cycle already carries beat 0.
        if (resp_seen) begin
          rbuf_d[{beat_q, 4'b0000} +: 16] = D2;
          beat_d  = beat_inc;
          tmo_d   = '0;
          state_d = S_RD_DATA;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) state_d = S_ERR;
        end
      end
      S_RD_DATA: begin
        if (resp_seen) begin
          rbuf_d[{beat_q, 4'b0000} +: 16] = D2;
          beat_d = beat_inc;
          if (beat_q == LAST_BEAT) begin
            rdata_d = rbuf_d;
            state_d = S_DONE;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) state_d = S_ERR;
        end
      end
      S_WR_DATA: begin
        c2_oe  = 1'b1;
        d2_oe  = 1'b1;
        c2_out = CMD_WR;
        d2_out = wdata_q[{beat_q, 4'b0000} +: 16];
        beat_d = beat_inc;
        if (beat_q == LAST_BEAT) begin
          tmo_d   = '0;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (resp_seen) begin
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) state_d = S_ERR;
        end
      end
      S_DONE: begin
        c2_oe   = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        c2_oe   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  // Drive enables decode straight from the state so an async reset releases D2 at once.
  assign C2 = c2_oe ? c2_out : 2'bzz;
  assign D2 = d2_oe ? d2_out : 16'hzzzz;
  assign A2 = addr_q;

  assign req_if.req_ready  = (state_q == S_IDLE);
  assign req_if.resp_valid = (state_q == S_DONE);
  assign req_if.resp_err   = (state_q == S_ERR);
  assign req_if.resp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_line_master.sv
// Randomised bench for mem_line_master with a scripted bus-2 memory responder.
module tb_mem_line_master;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        RESET;
  logic [14:0] a2;
  tri1  [1:0]  c2_w;
  tri1  [15:0] d2_w;

  logic        mem_c_en, mem_d_en;
  logic [1:0]  mem_c;
  logic [15:0] mem_d;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] last_rdata;

  mem_line_master_if #(.ADDR_W(15), .LINE_W(128)) cif ();

  mem_line_master #(.LINE_BEATS(8), .ADDR_W(15), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .RESET  (RESET),
    .req_if (cif),
    .A2     (a2),
    .C2     (c2_w),
    .D2     (d2_w)
  );

  assign c2_w = mem_c_en ? mem_c : 2'bzz;
  assign d2_w = mem_d_en ? mem_d : 16'hzzzz;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Released bus reads as the pull-up value: C2=2'b11, D2=16'hFFFF.
  task automatic run_txn(input logic wr, input logic [14:0] addr, input logic [127:0] line,
                         input int wait_cyc, input int stall_at, input int stall_len,
                         input logic no_resp, input logic hold);
    int plan[$];
    @(posedge clk); #1;
    cif.req_valid = 1'b1;
    cif.req_write = wr;
    cif.req_addr  = addr;
    cif.req_wdata = wr ? line : rand128();
    @(negedge clk);
    check_eq("accept_ready", cif.req_ready, 1);
    check_eq("idle_c2_nop", c2_w, 0);
    @(posedge clk); #1;
    if (!hold) cif.req_valid = 1'b0;
    if (!wr) begin
      @(negedge clk);
      check_eq("rd_cmd_c2", c2_w, 2);
      check_eq("rd_cmd_a2", a2, addr);
      check_eq("busy_ready", cif.req_ready, 0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("wr_c2", c2_w, 3);
        check_eq("wr_a2", a2, addr);
        check_eq("wr_d2", d2_w, {line[8*(2*i+1) +: 8], line[8*(2*i) +: 8]});
        check_eq("wr_busy_ready", cif.req_ready, 0);
      end
    end

    if (no_resp) begin
      repeat (TIMEOUT) plan.push_back(-1);
    end else begin
      repeat (wait_cyc) plan.push_back(-1);
      if (wr) plan.push_back(0);
      else begin
        for (int b = 0; b < 8; b++) begin
          plan.push_back(b);
          if (b == stall_at) repeat (stall_len) plan.push_back(-1);
        end
      end
    end

    foreach (plan[k]) begin
      @(posedge clk); #1;
      if (plan[k] < 0) begin
        mem_c_en = 1'b0;
        mem_d_en = 1'b0;
      end else begin
        mem_c_en = 1'b1;
        mem_c    = 2'd1;
        mem_d_en = !wr;
        mem_d    = line[16*plan[k] +: 16];
      end
      @(negedge clk);
      check_eq("wait_resp_valid", cif.resp_valid, 0);
      check_eq("wait_resp_err", cif.resp_err, 0);
      check_eq("wait_ready", cif.req_ready, 0);
      if (plan[k] < 0) begin
        check_eq("released_d2", d2_w, 16'hFFFF);
        if (!wr) check_eq("released_c2", c2_w, 2'b11);
      end
    end

    @(posedge clk); #1;
    mem_c_en = 1'b0;
    mem_d_en = 1'b0;
    @(negedge clk);
    if (no_resp) begin
      check_eq("tmo_resp_err", cif.resp_err, 1);
      check_eq("tmo_resp_valid", cif.resp_valid, 0);
    end else begin
      if (!wr) last_rdata = line;
      check_eq("done_resp_valid", cif.resp_valid, 1);
      check_eq("done_resp_err", cif.resp_err, 0);
      check_eq("done_rdata", cif.resp_rdata, last_rdata);
    end
    check_eq("end_c2_nop", c2_w, 0);
    check_eq("end_d2_released", d2_w, 16'hFFFF);
  endtask

  logic [127:0] line_a, line_w;
  logic         r_wr;
  logic [14:0]  r_addr;
  int           r_wait, r_stall_at, r_stall_len;

  initial begin
    RESET = 1'b0;
    mem_c_en = 1'b0; mem_d_en = 1'b0; mem_c = 2'd0; mem_d = 16'h0;
    cif.req_valid = 1'b0; cif.req_write = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", cif.req_ready, 1);
    check_eq("rst_resp_valid", cif.resp_valid, 0);
    check_eq("rst_resp_err", cif.resp_err, 0);
    check_eq("rst_rdata", cif.resp_rdata, 0);
    check_eq("rst_a2", a2, 0);
    check_eq("rst_c2", c2_w, 0);
    check_eq("rst_d2", d2_w, 16'hFFFF);
    @(posedge clk); #1;
    RESET = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", cif.req_ready, 1);

    for (int k = 0; k < 16; k++) begin
      line_a[8*k +: 8] = 8'(k);
      line_w[8*k +: 8] = 8'(8'hA0 + k);
    end
    run_txn(1'b0, 15'h1234, line_a, 10, -1, 0, 1'b0, 1'b0);
    run_txn(1'b1, 15'h7FFF, line_w, 3, -1, 0, 1'b0, 1'b0);
    run_txn(1'b0, 15'h0042, rand128(), 2, 4, 2, 1'b0, 1'b0);
    run_txn(1'b0, 15'h0100, rand128(), 1, -1, 0, 1'b0, 1'b1);
    run_txn(1'b0, 15'h0101, rand128(), 0, -1, 0, 1'b0, 1'b0);
    run_txn(1'b0, 15'h5555, rand128(), 0, -1, 0, 1'b1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      r_wr        = 1'($urandom_range(0, 1));
      r_addr      = 15'($urandom());
      r_wait      = $urandom_range(0, 6);
      r_stall_at  = $urandom_range(0, 6);
      r_stall_len = $urandom_range(0, 3);
      run_txn(r_wr, r_addr, rand128(), r_wait, r_stall_at, r_stall_len, 1'b0, 1'b0);
    end

    // Reset while the fourth write beat is on the bus.
    @(posedge clk); #1;
    cif.req_valid = 1'b1; cif.req_write = 1'b1; cif.req_addr = 15'h0ABC; cif.req_wdata = line_w;
    @(posedge clk); #1;
    cif.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("mid_wr_beat3", d2_w, 16'hA7A6);
    #1 RESET = 1'b0;
    #1;
    check_eq("mid_rst_c2", c2_w, 0);
    check_eq("mid_rst_d2", d2_w, 16'hFFFF);
    check_eq("mid_rst_valid", cif.resp_valid, 0);
    last_rdata = '0;
    @(posedge clk); #1;
    RESET = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("after_rst_valid", cif.resp_valid, 0);
      check_eq("after_rst_ready", cif.req_ready, 1);
    end
    check_eq("after_rst_rdata", cif.resp_rdata, last_rdata);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_line_master.md
Name: mem_line_master

Overview:
- Cache-side master of the bus-2 link, one stage upstream of the memory controller.
- Accepts line-granular read/write requests from the L1 cache control logic and serialises each 16-byte line into 8 16-bit beats on D2/C2/A2.
- Collects the memory response and returns it to the cache.
- Owns C2 and D2 except while the memory side is responding.

Parameters:
- LINE_BEATS, 8, 16-bit beats per 16-byte line.
- ADDR_W, 15, line address width; byte address without the 4-bit offset.
- TIMEOUT, 255, maximum cycles waited for a memory response before flagging an error.

Ports:
- clk  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache requests a line transfer.
- req_write  in  1  1 = WRITE_LINE, 0 = READ_LINE; sampled with req_valid.
- req_addr  in  15  line address; sampled with req_valid.
- req_wdata  in  128  write line; byte k at bits [8k+7:8k]; sampled with req_valid.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle pulse when a transfer completes.
- resp_rdata  out  128  read line; valid with resp_valid on reads; holds last value otherwise.
- resp_err  out  1  one-cycle pulse, in place of resp_valid, on timeout.
- A2  out  15  line address to memory.
- C2  inout  2  command bus. Codes: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3.
- D2  inout  16  data bus; beat i carries bytes 2i (D2[7:0]) and 2i+1 (D2[15:8]).

Behaviour:
- Reset (RESET=0, async):
  - State goes to IDLE. C2 is driven NOP. D2 is high-Z. A2=0.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, beat and timeout counters cleared.
  - Reset mid-transfer abandons the transfer with no response pulse.
- Handshake: a request is accepted on the posedge where req_valid && req_ready. req_addr, req_write and req_wdata are latched. req_ready falls on the next cycle. req_valid while busy is ignored.
- IDLE: drive C2=NOP; D2 high-Z.
- RD_CMD (1 cycle): drive C2=READ_LINE and A2=latched address.
- RD_WAIT:
  - Release C2 and D2 (high-Z); A2 holds.
  - Count cycles. The first cycle with C2==RESPONSE is beat 0; go to RD_DATA.
  - If the count reaches TIMEOUT, go to ERR.
- RD_DATA:
  - Sample D2 on every cycle with C2==RESPONSE.
  - After LINE_BEATS beats (beat 0 sampled in RD_WAIT), go to DONE.
  - If C2 leaves RESPONSE before all beats arrive, stall the beat counter and keep counting toward the timeout.
- WR_DATA (LINE_BEATS cycles):
  - Drive C2=WRITE_LINE, A2=address, D2=beat i on cycle i, with i=0..7 from the first cycle.
  - Then go to WR_WAIT.
- WR_WAIT: release C2 and D2. Wait for one cycle with C2==RESPONSE, then go to DONE. Timeout rule is as in RD_WAIT.
- DONE (1 cycle):
  - resp_valid=1. resp_rdata is updated for reads and unchanged for writes.
  - Drive C2=NOP. Go to IDLE.
- ERR (1 cycle): resp_err=1; drive C2=NOP; go to IDLE.
- Bus ownership turnaround: the master drives C2/D2 only in IDLE, RD_CMD, WR_DATA, DONE and ERR. It never drives in the same cycle it samples.
- Latency:
  - Read = 1 (CMD) + memory wait + 8 beats + 1 (DONE).
  - Write = 8 + memory wait + 1.
  - Back-to-back: the next request can be accepted on the cycle after DONE.
- Counters: beat counter 3 bits wraps exactly at LINE_BEATS. Timeout counter saturates at TIMEOUT and clears on state entry.

Test Plan:
- Reset mid-WR_DATA (beat 3) -> C2 reads NOP, D2 is high-Z immediately, no resp_valid, req_ready=1 after release.
- Read addr 0x1234; memory model responds after 10 cycles with beats 0x0100, 0x0302, …, 0x0F0E -> resp_rdata=0x0F0E…0100, resp_valid one pulse 20 cycles after accept.
- Write addr 0x7FFF, wdata bytes 0xA0..0xAF -> D2 shows 0xA1A0, 0xA3A2, …, 0xAFAE on 8 consecutive cycles with C2=3 and A2=0x7FFF; after RESPONSE, resp_valid pulses and resp_rdata is unchanged.
- Read where the memory stalls RESPONSE for 2 cycles after beat 4 -> 8 beats still assembled correctly.
- req_valid held during a read -> second request accepted only on the cycle after DONE.
- No memory response with TIMEOUT=255 -> resp_err pulses exactly 255 cycles into RD_WAIT and resp_valid never asserts.
